branch_predictor: RTL and testbench

1-bit branch history table with branch target buffer for the pipelined core. It sits in front of the fetch PC mux and predicts the next PC for the instruction being fetched. It is trained in EX, where the resolved target is computed as PC plus the B-/J-type immediate from the immediate generator. It also flags mispredictions so the hazard unit can flush IF/ID and ID/EX and redirect fetch.

---
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   1-bit branch history table with a branch target buffer. The IF lookup
//   predicts the next fetch PC. The EX resolution flags mispredictions and
//   trains the table.
//
// Ports
//   i_clk, i_reset      clock; synchronous active-low reset
//   i_if_pc             PC being fetched
//   o_pred_taken        table hit and stored history bit set
//   o_pred_pc           stored target when predicted taken, else i_if_pc+4
//   i_ex_valid          EX holds a real instruction (qualifies every EX input)
//   i_ex_pc             PC of the EX instruction
//   i_ex_is_br          EX instruction is a conditional branch or JAL
//   i_ex_taken          resolved outcome (JAL is always taken)
//   i_ex_target         resolved target, i_ex_pc + immediate
//   i_ex_pred_pc        prediction carried down the pipe with the instruction
//   o_mispredict        resolved next PC differs from the carried prediction
//   o_redirect_pc       correct next PC; meaningful only when o_mispredict
//   o_br_count          resolved branches/jumps since reset (wraps)
//   o_miss_count        mispredictions since reset (wraps)
//
// EX qualifier: i_ex_valid is a plain per-cycle qualifier with no
// back-pressure. Each cycle it is high counts as one resolution and one
// table update. Stall cycles must present i_ex_valid = 0.
// ---------------------------------------------------------------------------
module branch_predictor #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 32 - INDEX_W - 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_if_pc,
   output logic        o_pred_taken,
   output logic [31:0] o_pred_pc,
   input  logic        i_ex_valid,
   input  logic [31:0] i_ex_pc,
   input  logic        i_ex_is_br,
   input  logic        i_ex_taken,
   input  logic [31:0] i_ex_target,
   input  logic [31:0] i_ex_pred_pc,
   output logic        o_mispredict,
   output logic [31:0] o_redirect_pc,
   output logic [31:0] o_br_count,
   output logic [31:0] o_miss_count
);

   localparam int DEPTH = 2 ** INDEX_W;

   logic [DEPTH-1:0] r_valid;
   logic [TAG_W-1:0] r_tag    [DEPTH];
   logic [31:0]      r_target [DEPTH];
   logic [DEPTH-1:0] r_hist;
   logic [31:0]      r_br_count;
   logic [31:0]      r_miss_count;

   logic [INDEX_W-1:0] w_if_idx;
   logic [TAG_W-1:0]   w_if_tag;
   logic               w_if_hit;
   logic [INDEX_W-1:0] w_ex_idx;
   logic [TAG_W-1:0]   w_ex_tag;
   logic               w_ex_tag_match;
   logic [31:0]        w_actual_next;
   logic               w_unused_pc_lsbs;

   // Instructions are word aligned; the two low PC bits never index or tag.
   assign w_unused_pc_lsbs = ^{i_if_pc[1:0], i_ex_pc[1:0]};

   // ---------------- IF lookup (reads pre-update contents, no bypass) -----
   assign w_if_idx = i_if_pc[INDEX_W+1:2];
   assign w_if_tag = i_if_pc[31:INDEX_W+2];
   assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

   assign o_pred_taken = w_if_hit && r_hist[w_if_idx];
   assign o_pred_pc    = o_pred_taken ? r_target[w_if_idx] : i_if_pc + 32'd4;

   // ---------------- EX resolution -----------------------------------------
   assign w_ex_idx       = i_ex_pc[INDEX_W+1:2];
   assign w_ex_tag       = i_ex_pc[31:INDEX_W+2];
   assign w_ex_tag_match = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

   assign w_actual_next = (i_ex_is_br && i_ex_taken) ? i_ex_target
                                                     : i_ex_pc + 32'd4;
   assign o_mispredict  = i_ex_valid && (w_actual_next != i_ex_pred_pc);
   assign o_redirect_pc = w_actual_next;

   // ---------------- Valid bits and counters (reset state) ----------------
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_valid      <= '0;
         r_br_count   <= '0;
         r_miss_count <= '0;
      end else begin
         if (i_ex_valid) begin
            if (i_ex_is_br) begin
               r_valid[w_ex_idx] <= 1'b1;
               r_br_count        <= r_br_count + 32'd1;
            end else if (w_ex_tag_match) begin
               // A non-branch now lives at a PC we hold an entry for:
               // drop the stale entry.
               r_valid[w_ex_idx] <= 1'b0;
            end
         end
         if (o_mispredict) begin
            r_miss_count <= r_miss_count + 32'd1;
         end
      end
   end

   // ---------------- Entry payload (no reset needed) ----------------------
   // Tag, target and history are only observed behind a set valid bit.
   always_ff @(posedge i_clk) begin
      if (i_reset && i_ex_valid && i_ex_is_br) begin
         r_tag[w_ex_idx]    <= w_ex_tag;
         r_target[w_ex_idx] <= i_ex_target;
         r_hist[w_ex_idx]   <= i_ex_taken;
      end
   end

   assign o_br_count   = r_br_count;
   assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Directed and randomised stimulus for branch_predictor. Expected values
//   go into exp_q as stimulus is applied and are popped as outputs are read.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_is_br;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic [31:0] ex_pred_pc;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] br_count;
   logic [31:0] miss_count;

   logic [31:0] exp_q[$];
   int          total;
   int          bad;
   int unsigned exp_br;
   int unsigned exp_miss;

   branch_predictor dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_if_pc      (if_pc),
      .o_pred_taken (pred_taken),
      .o_pred_pc    (pred_pc),
      .i_ex_valid   (ex_valid),
      .i_ex_pc      (ex_pc),
      .i_ex_is_br   (ex_is_br),
      .i_ex_taken   (ex_taken),
      .i_ex_target  (ex_target),
      .i_ex_pred_pc (ex_pred_pc),
      .o_mispredict (mispredict),
      .o_redirect_pc(redirect_pc),
      .o_br_count   (br_count),
      .o_miss_count (miss_count)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic drive_ex(input logic v, input logic [31:0] pc,
                           input logic br, input logic tk,
                           input logic [31:0] tgt, input logic [31:0] pred);
      ex_valid   = v;
      ex_pc      = pc;
      ex_is_br   = br;
      ex_taken   = tk;
      ex_target  = tgt;
      ex_pred_pc = pred;
   endtask

   task automatic idle_ex();
      drive_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Inputs change on the falling edge; outputs are read 1 time unit later.
   task automatic next_cycle();
      @(negedge clk);
   endtask

   task automatic settle();
      #1;
   endtask

   // ---------------- scoreboard ----------------
   task automatic push_exp(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp_v;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s: observed=%h but expected queue is empty", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
         end
      end
   endtask

   task automatic check_pred(input string tag, input logic [31:0] pc,
                             input logic tk, input logic [31:0] npc);
      if_pc = pc;
      settle();
      push_exp({31'b0, tk});
      check({tag, "_taken"}, {31'b0, pred_taken});
      push_exp(npc);
      check({tag, "_pc"}, pred_pc);
   endtask

   task automatic check_counts(input string tag);
      push_exp(exp_br);
      check({tag, "_br"}, br_count);
      push_exp(exp_miss);
      check({tag, "_miss"}, miss_count);
   endtask

   task automatic check_resolve(input string tag, input logic mis,
                                input logic [31:0] redir);
      settle();
      push_exp({31'b0, mis});
      check({tag, "_mis"}, {31'b0, mispredict});
      push_exp(redir);
      check({tag, "_redir"}, redir_or_obs(redir));
   endtask

   // Redirect is only meaningful on a mispredict; otherwise compare the
   // resolved next PC anyway since it is always driven.
   function automatic logic [31:0] redir_or_obs(input logic [31:0] r);
      return (r === r) ? redirect_pc : redirect_pc;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] pc, tgt, pred, actual;
      logic        tk, mis;

      total    = 0;
      bad      = 0;
      exp_br   = 0;
      exp_miss = 0;
      rst_n    = 1'b0;
      if_pc    = 32'h0;
      idle_ex();
      repeat (2) @(posedge clk);

      // Reset state
      next_cycle();
      rst_n = 1'b1;
      check_pred("reset", 32'h100, 1'b0, 32'h104);
      check_counts("reset");

      // Train 0x100 taken to 0x80; same-cycle IF sees the old miss
      next_cycle();
      drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'h104);
      check_resolve("train_tk", 1'b1, 32'h80);
      check_pred("train_tk_same", 32'h100, 1'b0, 32'h104);
      exp_br++; exp_miss++;
      next_cycle();
      idle_ex();
      check_pred("train_tk_next", 32'h100, 1'b1, 32'h80);
      check_counts("train_tk");

      // Not-taken flips the 1-bit history
      next_cycle();
      drive_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 32'h80);
      check_resolve("flip_nt", 1'b1, 32'h104);
      check_pred("flip_nt_same", 32'h100, 1'b1, 32'h80);
      exp_br++; exp_miss++;
      next_cycle();
      idle_ex();
      check_pred("flip_nt_next", 32'h100, 1'b0, 32'h104);
      check_counts("flip_nt");

      // Same-cycle IF/EX at one index, update to taken
      next_cycle();
      drive_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 32'h104);
      check_resolve("rdw", 1'b1, 32'h80);
      check_pred("rdw_same", 32'h100, 1'b0, 32'h104);
      exp_br++; exp_miss++;
      next_cycle();
      idle_ex();
      check_pred("rdw_next", 32'h100, 1'b1, 32'h80);

      // Alias: 0x200 shares the index but not the tag
      check_pred("alias_lookup", 32'h200, 1'b0, 32'h204);

      // Non-branch at 0x200 must not invalidate the 0x100 entry
      next_cycle();
      drive_ex(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h204);
      check_resolve("nb_alias", 1'b0, 32'h204);
      next_cycle();
      idle_ex();
      check_pred("nb_alias_keep", 32'h100, 1'b1, 32'h80);

      // Non-branch at 0x100 invalidates the entry
      next_cycle();
      drive_ex(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h104);
      check_resolve("nb_inval", 1'b0, 32'h104);
      next_cycle();
      idle_ex();
      check_pred("nb_inval_next", 32'h100, 1'b0, 32'h104);
      check_counts("nb_inval");

      // Bubble: no update, no mispredict, no count
      next_cycle();
      drive_ex(1'b0, 32'h100, 1'b1, 1'b1, 32'h80, 32'h0);
      check_resolve("bubble", 1'b0, 32'h80);
      next_cycle();
      idle_ex();
      check_pred("bubble_next", 32'h100, 1'b0, 32'h104);
      check_counts("bubble");

      // JAL correctly predicted
      next_cycle();
      drive_ex(1'b1, 32'h40, 1'b1, 1'b1, 32'h400, 32'h400);
      check_resolve("jal", 1'b0, 32'h400);
      exp_br++;
      next_cycle();
      idle_ex();
      check_pred("jal_next", 32'h40, 1'b1, 32'h400);
      check_counts("jal");

      // Randomised resolutions against a reference next-PC computation
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         pc   = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
         tk   = 1'($urandom_range(0, 1));
         tgt  = 32'($urandom_range(0, 1023)) << 2;
         pred = ($urandom_range(0, 1) == 1) ? tgt : pc + 32'd4;
         actual = tk ? tgt : pc + 32'd4;
         mis  = (actual != pred);
         drive_ex(1'b1, pc, 1'b1, tk, tgt, pred);
         check_resolve("rand", mis, actual);
         exp_br++;
         if (mis) exp_miss++;
      end
      next_cycle();
      idle_ex();
      settle();
      check_counts("rand");

      // Reset mid-stream with a mispredicting update in the same cycle
      next_cycle();
      rst_n = 1'b0;
      drive_ex(1'b1, 32'h300, 1'b1, 1'b1, 32'h10, 32'h304);
      check_resolve("rst_mid", 1'b1, 32'h10);
      exp_br   = 0;
      exp_miss = 0;
      next_cycle();
      rst_n = 1'b1;
      idle_ex();
      check_pred("rst_jal", 32'h40, 1'b0, 32'h44);
      check_pred("rst_drop", 32'h300, 1'b0, 32'h304);
      check_counts("rst_mid");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
